sevseg_digit_driver: RTL and testbench

//   Downstream of the one-hot anode rotator. Takes its anode_in[3:0] (0001->0010->0100->1000->0001)
//   and drives a 4-digit common-anode 7-segment display: selects the digit nibble, decodes it, and

---
 rtl/sevseg_digit_driver.sv | 129 ++++++++++++
 tb/tb_sevseg_digit_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_digit_driver.sv
// rtl/sevseg_digit_driver.sv - 4-digit common-anode 7-seg driver with double-buffered value and dead-time blanking
// Optional: SEVSEG_HEX_EN enables A-F glyphs (otherwise A-F show blank)
module sevseg_digit_driver #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anode_in,
    input  logic [15:0] val_in,
    input  logic [3:0]  dp_in,
    input  logic        val_valid,
    output logic        val_ready,
    output logic [3:0]  an_out,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
`ifdef SEVSEG_HEX_EN
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
`endif
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [3:0]    anode_q;
    logic [15:0]   active_val;
    logic [3:0]    active_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_full;
    logic [CW-1:0] blank_cnt;

    logic          change;
    logic          boundary;
    logic          capture;
    logic          onehot;
    logic [3:0]    nibble;
    logic          dp_bit;

    assign val_ready = ~pend_full;
    assign change    = (anode_in != anode_q);
    assign boundary  = change && (anode_in == 4'b0001);
    assign capture   = val_valid && val_ready;

    // Digit selection follows the registered anode so data and anode move together
    always_comb begin
        nibble = 4'h0;
        dp_bit = 1'b0;
        onehot = 1'b1;
        case (anode_q)
            4'b0001: begin nibble = active_val[3:0];   dp_bit = active_dp[0]; end
            4'b0010: begin nibble = active_val[7:4];   dp_bit = active_dp[1]; end
            4'b0100: begin nibble = active_val[11:8];  dp_bit = active_dp[2]; end
            4'b1000: begin nibble = active_val[15:12]; dp_bit = active_dp[3]; end
            default: onehot = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q    <= 4'h0;
            active_val <= 16'h0000;
            active_dp  <= 4'h0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_full  <= 1'b0;
        end else begin
            anode_q <= anode_in;
            // Commit and capture are exclusive: capture needs an empty pending buffer
            if (boundary && pend_full) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
                pend_full  <= 1'b0;
            end else if (capture) begin
                pend_val  <= val_in;
                pend_dp   <= dp_in;
                pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt <= '0;
        end else if (change) begin
            blank_cnt <= CW'(BLANK_CYCLES);
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_out <= 4'hF;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else if ((blank_cnt == '0) && onehot) begin
            an_out <= ~anode_q;
            seg    <= decode(nibble);
            dp     <= ~dp_bit;
        end else begin
            an_out <= 4'hF;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sevseg_digit_driver.sv
// tb/tb_sevseg_digit_driver.sv - scoreboard bench for sevseg_digit_driver against a cycle-age reference model
module tb_sevseg_digit_driver;

    localparam int BLANK = 4;
    localparam int AGE_MAX = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode_in = 4'h0;
    logic [15:0] val_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        val_valid = 1'b0;
    logic        val_ready;
    logic [3:0]  an_out;
    logic [6:0]  seg;
    logic        dp;

    sevseg_digit_driver #(.BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .anode_in(anode_in), .val_in(val_in), .dp_in(dp_in),
        .val_valid(val_valid), .val_ready(val_ready), .an_out(an_out), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    logic [6:0]  dec_tab[16];
    logic [3:0]  m_anode_q;
    int          m_age;
    logic [15:0] m_active;
    logic [3:0]  m_active_dp;
    logic [15:0] m_pend;
    logic [3:0]  m_pend_dp;
    bit          m_full;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Model state is "as of the last clock edge"; age counts edges since the last anode change
    task automatic model_reset();
        m_anode_q   = 4'h0;
        m_age       = AGE_MAX;
        m_active    = 16'h0;
        m_active_dp = 4'h0;
        m_pend      = 16'h0;
        m_pend_dp   = 4'h0;
        m_full      = 1'b0;
    endtask

    task automatic step(input logic [3:0] a, input logic [15:0] v, input logic [3:0] d, input logic vv);
        exp_t e;
        int   idx;
        bit   chg, bnd, cap;
        @(negedge clk);
        #2;
        anode_in  = a;
        val_in    = v;
        dp_in     = d;
        val_valid = vv;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (m_age >= BLANK && $countones(m_anode_q) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (m_anode_q[i]) idx = i;
            e.an  = ~m_anode_q;
            e.seg = dec_tab[m_active[idx*4 +: 4]];
            e.dp  = ~m_active_dp[idx];
        end
        chg = (a != m_anode_q);
        bnd = chg && (a == 4'b0001);
        cap = vv && !m_full;
        if (bnd && m_full) begin
            m_active    = m_pend;
            m_active_dp = m_pend_dp;
            m_full      = 1'b0;
        end
        if (cap) begin
            m_pend    = v;
            m_pend_dp = d;
            m_full    = 1'b1;
        end
        m_age     = chg ? 0 : ((m_age < AGE_MAX) ? m_age + 1 : m_age);
        m_anode_q = a;
        e.rdy     = !m_full;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) step(a, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic frame(input int dwell);
        hold(4'b0001, dwell);
        hold(4'b0010, dwell);
        hold(4'b0100, dwell);
        hold(4'b1000, dwell);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        anode_in  = 4'h0;
        val_valid = 1'b0;
        #1;
        chk("rst_an_out", 16'(an_out), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_val_ready", 16'(val_ready), 16'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({an_out, seg, dp, val_ready} !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got an=%h seg=%h dp=%b rdy=%b, want an=%h seg=%h dp=%b rdy=%b",
                         $time, an_out, seg, dp, val_ready, e.an, e.seg, e.dp, e.rdy);
            end
        end
    end

    initial begin
        int         r;
        int         dw;
        logic [3:0] a;
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef SEVSEG_HEX_EN
                    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
                    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        model_reset();
        do_reset();

        hold(4'b0001, 8);

        hold(4'b0010, 6);
        step(4'b0100, 16'h1234, 4'b0100, 1'b1);
        hold(4'b0100, 5);
        hold(4'b1000, 6);
        frame(6);
        frame(6);

        step(4'b0001, 16'h5678, 4'b0001, 1'b1);
        step(4'b0001, 16'h9999, 4'b1111, 1'b1);
        hold(4'b0001, 4);
        hold(4'b0010, 6);
        step(4'b0100, 16'h4321, 4'b1000, 1'b1);
        hold(4'b0100, 5);
        hold(4'b1000, 6);
        frame(6);

        hold(4'b0010, 2);
        hold(4'b0100, 7);

        hold(4'b1000, 6);
        step(4'b0001, 16'hABCD, 4'b0010, 1'b1);
        hold(4'b0001, 5);
        hold(4'b0010, 6);
        hold(4'b0100, 6);
        hold(4'b1000, 6);
        frame(6);
        frame(6);

        hold(4'b0011, 6);
        hold(4'b0000, 3);
        hold(4'b0001, 6);
        step(4'b0010, 16'h7777, 4'b0101, 1'b1);
        hold(4'b0010, 3);
        do_reset();
        hold(4'b0001, 8);
        frame(5);

        r = 0;
        for (int k = 0; k < 400; k++) begin
            a = 4'(4'b0001 << r);
            if ($urandom_range(0, 15) == 0) a = 4'($urandom);
            dw = $urandom_range(1, 8);
            for (int j = 0; j < dw; j++)
                step(a, 16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
            r = (r + 1) % 4;
        end
        frame(6);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
